// File: rtl/leaf_packet_router.sv
// Leaf packet router: classifies packets arriving from a BFT leaf and steers
// them into a stream FIFO, a config FIFO, the RISC-V instruction write port
// or the kernel start control. Packets refused by a full FIFO are dropped,
// retransmission is requested, and the drop is counted.

// First-word-fall-through FIFO. A push into a full FIFO is refused even when
// the same cycle pops, so the caller can decide on a drop from the
// occupancy before the clock edge alone.
module leaf_packet_router_fifo #(
  parameter int W     = 97,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop_ready,
  output logic         full,
  output logic         valid,
  output logic [W-1:0] data
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic          do_push, do_pop;

  assign full    = (cnt_q == DEPTH_C);
  assign valid   = (cnt_q != '0);
  assign do_pop  = valid && pop_ready;
  assign do_push = push && !full;
  // Empty FIFO presents zero data rather than stale storage.
  assign data    = valid ? mem_q[rd_q] : '0;

  // Next pointer/occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
    if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
    else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
  end

  // Pointer and occupancy registers; reset flushes the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage write; contents need no reset because data is gated by valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data;
  end
endmodule

module leaf_packet_router #(
  parameter int PACKET_BITS     = 97,
  parameter int PAYLOAD_BITS    = 64,
  parameter int NUM_LEAF_BITS   = 6,
  parameter int NUM_PORT_BITS   = 4,
  parameter int STREAM_PORT_MIN = 2,
  parameter int STREAM_PORT_MAX = 8,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PACKET_BITS-1:0] din,
  output logic                   resend_out,
  output logic [PACKET_BITS-1:0] stream_data,
  output logic                   stream_valid,
  input  logic                   stream_ready,
  output logic [PACKET_BITS-1:0] cfg_data,
  output logic                   cfg_valid,
  input  logic                   cfg_ready,
  output logic [31:0]            instr_packet,
  output logic                   instr_wr_en,
  output logic                   ap_start,
  output logic [15:0]            drop_count
);
  // Port field sits directly below the leaf field.
  localparam int PORT_HI = PACKET_BITS - 2 - NUM_LEAF_BITS;
  localparam logic [NUM_PORT_BITS-1:0] P_MIN = NUM_PORT_BITS'(STREAM_PORT_MIN);
  localparam logic [NUM_PORT_BITS-1:0] P_MAX = NUM_PORT_BITS'(STREAM_PORT_MAX);

  localparam logic [2:0] C_NONE   = 3'd0;
  localparam logic [2:0] C_CFG    = 3'd1;
  localparam logic [2:0] C_STREAM = 3'd2;
  localparam logic [2:0] C_INSTR  = 3'd3;
  localparam logic [2:0] C_SET    = 3'd4;
  localparam logic [2:0] C_CLR    = 3'd5;
  localparam logic [2:0] C_DISC   = 3'd6;

  logic                     pkt_vld;
  logic [NUM_PORT_BITS-1:0] port;
  logic [1:0]               cmd;
  logic [2:0]               cls;
  logic                     s_full, c_full;

  logic        resend_q, resend_d;
  logic        instr_wr_en_q, instr_wr_en_d;
  logic [31:0] instr_packet_q, instr_packet_d;
  logic        ap_start_q, ap_start_d;
  logic [15:0] drop_count_q, drop_count_d;

  assign pkt_vld = din[PACKET_BITS-1];
  assign port    = din[PORT_HI -: NUM_PORT_BITS];
  assign cmd     = din[PAYLOAD_BITS+1:PAYLOAD_BITS];

  // Packet classification; port 0 is the control port selected by cmd.
  always_comb begin
    cls = C_NONE;
    if (pkt_vld) begin
      if (port == '0) begin
        case (cmd)
          2'd0:    cls = C_CFG;
          2'd1:    cls = C_INSTR;
          2'd2:    cls = C_SET;
          default: cls = C_CLR;
        endcase
      end else if (port == NUM_PORT_BITS'(1) || port > P_MAX) begin
        cls = C_CFG;
      end else if (port >= P_MIN) begin
        cls = C_STREAM;
      end else begin
        cls = C_DISC;
      end
    end
  end

  leaf_packet_router_fifo #(.W(PACKET_BITS), .DEPTH(FIFO_DEPTH)) u_stream_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (cls == C_STREAM),
    .push_data (din),
    .pop_ready (stream_ready),
    .full      (s_full),
    .valid     (stream_valid),
    .data      (stream_data)
  );

  leaf_packet_router_fifo #(.W(PACKET_BITS), .DEPTH(FIFO_DEPTH)) u_cfg_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (cls == C_CFG),
    .push_data (din),
    .pop_ready (cfg_ready),
    .full      (c_full),
    .valid     (cfg_valid),
    .data      (cfg_data)
  );

  // Control outputs: refused-push resend, instruction write, start level, drops.
  always_comb begin
    resend_d       = (cls == C_STREAM && s_full) || (cls == C_CFG && c_full);
    instr_wr_en_d  = (cls == C_INSTR);
    instr_packet_d = (cls == C_INSTR) ? din[31:0] : 32'd0;
    ap_start_d     = ap_start_q;
    if (cls == C_SET) ap_start_d = 1'b1;
    if (cls == C_CLR) ap_start_d = 1'b0;
    drop_count_d   = drop_count_q;
    if ((resend_d || cls == C_DISC) && drop_count_q != 16'hFFFF)
      drop_count_d = drop_count_q + 16'd1;
  end

  // Control registers; a packet seen during reset is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      resend_q       <= 1'b0;
      instr_wr_en_q  <= 1'b0;
      instr_packet_q <= 32'd0;
      ap_start_q     <= 1'b0;
      drop_count_q   <= 16'd0;
    end else begin
      resend_q       <= resend_d;
      instr_wr_en_q  <= instr_wr_en_d;
      instr_packet_q <= instr_packet_d;
      ap_start_q     <= ap_start_d;
      drop_count_q   <= drop_count_d;
    end
  end

  assign resend_out   = resend_q;
  assign instr_wr_en  = instr_wr_en_q;
  assign instr_packet = instr_packet_q;
  assign ap_start     = ap_start_q;
  assign drop_count   = drop_count_q;
endmodule

// File: doc/leaf_packet_router.md
LEAF_PACKET_ROUTER -- requirements
Module: leaf_packet_router

Interface
REQ-001 SHALL have parameter PACKET_BITS, default 97: BFT packet width; bit PACKET_BITS-1 is the valid bit.
REQ-002 SHALL have parameter PAYLOAD_BITS, default 64: payload width; cmd field = bits [PAYLOAD_BITS+1:PAYLOAD_BITS].
REQ-003 SHALL have parameter NUM_LEAF_BITS, default 6: leaf field = bits [PACKET_BITS-2 -: NUM_LEAF_BITS].
REQ-004 SHALL have parameter NUM_PORT_BITS, default 4: port field sits directly below the leaf field.
REQ-005 SHALL have parameter STREAM_PORT_MIN, default 2, and STREAM_PORT_MAX, default 8: inclusive stream port range.
REQ-006 SHALL have parameter FIFO_DEPTH, default 4 (power of 2, >=2): depth of each output FIFO.
REQ-007 SHALL have clk  input  1  clock; reset  input  1  reset, synchronous, active-high.
REQ-008 SHALL have din  input  PACKET_BITS  packet from BFT leaf.
REQ-009 SHALL have resend_out  output  1  retransmit request to BFT.
REQ-010 SHALL have stream_data  output  PACKET_BITS, stream_valid  output  1, stream_ready  input  1  stream channel.
REQ-011 SHALL have cfg_data  output  PACKET_BITS, cfg_valid  output  1, cfg_ready  input  1  config channel.
REQ-012 SHALL have instr_packet  output  32, instr_wr_en  output  1  RISC-V instruction write.
REQ-013 SHALL have ap_start  output  1  kernel start level.
REQ-014 SHALL have drop_count  output  16  count of rejected packets.

Function
REQ-015 SHALL classify a packet only when the valid bit = 1; invalid packets cause no effect.
REQ-016 SHALL classify: port 0 and cmd 0 -> CFG; port 0, cmd 1 -> INSTR; port 0, cmd 2 -> SET; port 0, cmd 3 -> CLR; port 1 or port > STREAM_PORT_MAX -> CFG; STREAM_PORT_MIN..STREAM_PORT_MAX -> STREAM; any other port -> DISCARD.
REQ-017 SHALL push CFG packets, unmodified, into the cfg FIFO and STREAM packets into the stream FIFO.
REQ-018 SHALL implement each FIFO first-word-fall-through: valid = non-empty, data = head entry, pop on valid && ready.
REQ-019 SHALL accept a push only if occupancy before the cycle is < FIFO_DEPTH; a same-cycle pop does not free space for a push into a full FIFO.
REQ-020 SHALL, when a push is refused, drop the packet, pulse resend_out high for exactly one cycle starting the next cycle, and increment drop_count.
REQ-021 SHALL saturate drop_count at 16'hFFFF.
REQ-022 SHALL, for INSTR, drive instr_wr_en = 1 and instr_packet = din[31:0] on the next cycle for one cycle; otherwise instr_wr_en = 0 and instr_packet = 0.
REQ-023 SHALL set ap_start to 1 the cycle after SET and clear it the cycle after CLR; otherwise hold.
REQ-024 SHALL count DISCARD packets in drop_count without asserting resend_out.
REQ-025 SHALL allow, on the same cycle, one push (at most one packet arrives), a pop on each FIFO, and a drop_count update.
REQ-026 SHALL keep FIFO pointers modulo FIFO_DEPTH and occupancy in clog2(FIFO_DEPTH)+1 bits, wrapping cleanly.
REQ-027 SHALL have a minimum latency of din -> stream_valid/cfg_valid of one cycle.

Reset
REQ-028 SHALL on reset drive stream_valid = 0, cfg_valid = 0, resend_out = 0, instr_wr_en = 0, instr_packet = 0, ap_start = 0, drop_count = 0, and stream_data/cfg_data = 0.
REQ-029 SHALL on reset mid-operation flush both FIFOs; a packet presented in the reset cycle is ignored.

Verification
REQ-030 SHALL cover: valid packet, port 3, payload 64'hA5 -> next cycle stream_valid = 1 and stream_data = packet; with ready = 1 -> valid = 0 the following cycle.
REQ-031 SHALL cover: stream_ready = 0 and 5 port-2 packets with default depth 4 -> 4 queued, 5th dropped, resend_out pulses once, drop_count = 1; then drain 4 in order.
REQ-032 SHALL cover: cfg FIFO full, push and pop in the same cycle -> push refused, resend_out pulses, occupancy = 3.
REQ-033 SHALL cover: port 0 cmd 1, din[31:0] = 32'hDEADBEEF -> instr_wr_en = 1 and instr_packet = 32'hDEADBEEF for one cycle; cmd 2 -> ap_start = 1 held; cmd 3 -> ap_start = 0.
REQ-034 SHALL cover: port 10 -> cfg FIFO; port 0 cmd 0 -> cfg FIFO; valid bit 0, port 3 -> no effect.
REQ-035 SHALL cover: reset asserted with 3 entries queued -> both valids 0 the next cycle, drop_count = 0, ap_start = 0.
